// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: RV32M/RV64M multiply/divide unit; one shared radix-2 shift-add / restoring-divide datapath.
// Latency: XLEN+1 cycles from accept to out_valid; divide special cases (and all multiplies when
//   MULDIV_FAST_MUL_EN is defined) raise out_valid in the cycle after accept.
// Backpressure: in_ready only in IDLE; result/tag held in DONE until out_ready; flush kills any in-flight op.
module riscv_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  // Iteration counter width, derived from XLEN.
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state, state_n;

  // Handshake/control strobes from the FSM
  logic accept;
  logic last_iter;
  logic fast_path;

  // Captured operation state
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] b_q;
  logic [CNT_W-1:0] cnt;

  // Request decode
  logic            a_signed;
  logic            b_signed;
  logic            sa;
  logic            sb;
  logic            neg_in;
  logic            div_zero;
  logic            div_ovf;
  logic            fast_mul;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] fast_result;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;

  // Single-cycle product of the sign-extended operands; the low 2*XLEN bits are exact
  assign fast_prod = (2*XLEN)'($signed({sa, in_a}) * $signed({sb, in_b}));
`endif

  // Decode the incoming request: signedness, magnitudes, result sign and the fast-path cases
  always_comb begin
    a_signed    = 1'b0;
    b_signed    = 1'b0;
    fast_mul    = 1'b0;
    fast_result = '0;
    case (in_op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    sa       = a_signed & in_a[XLEN-1];
    sb       = b_signed & in_b[XLEN-1];
    mag_a    = sa ? -in_a : in_a;
    mag_b    = sb ? -in_b : in_b;
    // A remainder takes the dividend's sign; quotients and products take sign(a)^sign(b)
    neg_in   = (in_op == OP_REM) ? sa : (sa ^ sb);
    div_zero = in_op[2] && (in_b == '0);
    div_ovf  = ((in_op == OP_DIV) || (in_op == OP_REM)) && (in_a == MIN_NEG) && (in_b == '1);
    if (div_zero) begin
      fast_result = in_op[1] ? in_a : '1;
    end else if (div_ovf) begin
      fast_result = in_op[1] ? '0 : in_a;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!in_op[2]) begin
      fast_mul    = 1'b1;
      fast_result = (in_op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
    fast_path = div_zero | div_ovf | fast_mul;
  end

  // Shared datapath signals
  logic              is_div;
  logic [XLEN:0]     shifted;
  logic [XLEN-1:0]   addend;
  logic [XLEN+1:0]   add_x;
  logic [XLEN+1:0]   add_y;
  logic [XLEN+1:0]   add_res;
  logic              add_c;
  logic [XLEN-1:0]   hi_n;
  logic [XLEN-1:0]   lo_n;
  logic [XLEN-1:0]   q_s;
  logic [XLEN-1:0]   r_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   final_result;

  // One iteration: a single adder either accumulates the multiplicand or trial-subtracts the divisor
  always_comb begin
    is_div  = op_q[2];
    shifted = {hi, lo[XLEN-1]};
    addend  = lo[0] ? b_q : '0;
    if (is_div) begin
      add_x = {1'b0, shifted};
      add_y = ~{2'b00, b_q};
      add_c = 1'b1;
    end else begin
      add_x = {2'b00, hi};
      add_y = {2'b00, addend};
      add_c = 1'b0;
    end
    add_res = add_x + add_y + {{(XLEN+1){1'b0}}, add_c};

    if (is_div) begin
      // Negative trial difference means the divisor did not fit: restore and shift in a 0
      if (add_res[XLEN+1]) begin
        hi_n = shifted[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b0};
      end else begin
        hi_n = add_res[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b1};
      end
    end else begin
      // {hi, lo} shifts right with the carry-out of the accumulate entering at the top
      hi_n = add_res[XLEN:1];
      lo_n = {add_res[0], lo[XLEN-1:1]};
    end

    prod_s = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    q_s    = neg_q ? -lo_n : lo_n;
    r_s    = neg_q ? -hi_n : hi_n;
    case (op_q)
      OP_MUL:                       final_result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_result = q_s;
      default:                      final_result = r_s;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic; flush wins over both handshakes
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    last_iter = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid && !flush) begin
          accept  = 1'b1;
          state_n = fast_path ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_n = S_IDLE;
        end else if (cnt == CNT_W'(XLEN-1)) begin
          last_iter = 1'b1;
          state_n   = S_DONE;
        end
      end
      S_DONE: begin
        if (flush || out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Operand capture at accept, one iteration per BUSY cycle, result latched on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      neg_q      <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      b_q        <= '0;
      cnt        <= '0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (accept) begin
      op_q    <= in_op;
      neg_q   <= neg_in;
      hi      <= '0;
      lo      <= mag_a;
      b_q     <= mag_b;
      cnt     <= '0;
      out_tag <= in_tag;
      if (fast_path) out_result <= fast_result;
    end else if ((state == S_BUSY) && !flush) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + 1'b1;
      if (last_iter) out_result <= final_result;
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb_riscv_muldiv_unit: directed and randomized checks of riscv_muldiv_unit against an arithmetic reference.
// Latency: cycle 0 is the accept cycle; expected out_valid cycle is XLEN+1, or 1 on the fast path.
// Backpressure: holds out_ready low in DONE and checks that result, tag and in_ready stay put.
module tb_riscv_muldiv_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int n_chk = 0;
  int n_err = 0;

  riscv_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, wait (bounded) for the result, check it, optionally hold off the consumer
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp, input int hold,
                       input string name);
    int cyc;
    int lat;
    lat = exp_lat(op, a, b);
    @(negedge clk);
    check({name, ":in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op = 3'($urandom); in_a = $urandom; in_b = $urandom; in_tag = TAG_W'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, ":latency"}, cyc, lat);
    check({name, ":result"}, out_result, exp);
    check({name, ":tag"}, out_tag, tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, ":hold_result"}, out_result, exp);
      check({name, ":hold_tag"}, out_tag, tag);
      check({name, ":hold_valid"}, out_valid, 1);
      check({name, ":hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, ":release_in_ready"}, in_ready, 1);
    check({name, ":release_valid"}, out_valid, 0);
  endtask

  // Kill a long divide in BUSY iteration 12 by flush or reset, then confirm recovery
  task automatic kill_test(input bit use_rst, input string name);
    int seen;
    seen = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd5; in_a = 32'd1000; in_b = 32'd7; in_tag = 5'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) begin
      @(posedge clk); #1;
      seen += int'(out_valid);
    end
    check({name, ":busy_before_kill"}, busy, 1);
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    check({name, ":in_ready"}, in_ready, 1);
    check({name, ":busy"}, busy, 0);
    check({name, ":out_valid"}, out_valid, 0);
    if (use_rst) begin
      check({name, ":out_result_reset"}, out_result, 0);
      check({name, ":out_tag_reset"}, out_tag, 0);
    end
    repeat (40) begin
      @(posedge clk); #1;
      seen += int'(out_valid);
    end
    check({name, ":no_result"}, seen, 0);
    do_op(3'd5, 32'd9, 32'd3, 5'd4, 32'd3, 0, {name, ":divu_after"});
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset:in_ready", in_ready, 1);
    check("reset:out_valid", out_valid, 0);
    check("reset:busy", busy, 0);
    check("reset:out_result", out_result, 0);
    check("reset:out_tag", out_tag, 0);
    rst = 1'b0;

    do_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFEB, 0, "mul");
    do_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 0, "mulh");
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2,  32'h7FFF_FFFF, 0, "mulhu");
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3,  32'h8000_0000, 0, "mulhsu");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFD, 0, "div");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 0, "rem");
    do_op(3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        0, "divu");
    do_op(3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         0, "remu");
    do_op(3'd4, 32'd12345,     32'd0,         5'd10, 32'hFFFF_FFFF, 0, "div_by0");
    do_op(3'd7, 32'd5,         32'd0,         5'd11, 32'd5,         0, "remu_by0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 0, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 0, "rem_ovf");
    do_op(3'd5, 32'd1000,      32'd10,        5'd14, 32'd100,       10, "backpressure");

    // A flushed request in IDLE must not be taken
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd5; in_a = 32'd9; in_b = 32'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle:busy", busy, 0);
    check("flush_idle:in_ready", in_ready, 1);
    check("flush_idle:out_valid", out_valid, 0);

    kill_test(1'b0, "flush_busy");
    kill_test(1'b1, "rst_busy");

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      do_op(op, a, b, TAG_W'(i), model(op, a, b), (i % 8 == 0) ? 2 : 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
